// File: rtl/fft_pkg.sv
// fft_pkg: shared constants and complex-sample types for the FFT output path.
// The top-level DW and FRAME_LEN parameters default to the constants here.
package fft_pkg;

   localparam int DW        = 32;
   localparam int FRAME_LEN = 1024;
   localparam int IDX_W     = $clog2(FRAME_LEN);

   typedef struct packed {
      logic [DW-1:0] re;
      logic [DW-1:0] im;
   } cplx_t;

   typedef struct packed {
      cplx_t a;
      cplx_t b;
   } cplx_pair_t;

endpackage

// File: rtl/pair_fifo.sv
// pair_fifo: synchronous-read FIFO with a prefetched head register.
// adv_i moves the read pointer; pop_i releases the entry from the count.
module pair_fifo #(
   parameter int DEPTH = 512,
   parameter int W     = 128
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic                     adv_i,
   input  logic                     pop_i,
   input  logic [W-1:0]             wdata_i,
   output logic [W-1:0]             rdata_o,
   output logic                     head_vld_o,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  rdata_q;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [AW:0]   ucnt_q, ucnt_d;
   logic          head_q, head_d;

   // ucnt counts entries not yet prefetched; a head written on this
   // very edge is not readable until the following cycle.
   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(push_i);
      rd_ptr_d = rd_ptr_q + AW'(adv_i);
      cnt_d    = cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
      ucnt_d   = ucnt_q + (AW+1)'(push_i) - (AW+1)'(adv_i);
      head_d   = (ucnt_d != '0) &&
                 !(push_i && (ucnt_d == (AW+1)'(1)));
   end

   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   always_ff @(posedge clk_i) begin
      rdata_q <= mem_q[rd_ptr_d];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ucnt_q   <= '0;
         head_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         ucnt_q   <= ucnt_d;
         head_q   <= head_d;
      end
   end

   assign rdata_o    = rdata_q;
   assign head_vld_o = head_q;
   assign full_o     = (cnt_q == (AW+1)'(DEPTH));
   assign level_o    = cnt_q;

endmodule

// File: rtl/fft_pair_serializer.sv
// fft_pair_serializer: buffers butterfly output pairs, emits A then B.
// FFT_OUT_SCALE_EN: output words are arithmetically shifted right by 1.
module fft_pair_serializer #(
   parameter int DEPTH     = 512,
   parameter int FRAME_LEN = fft_pkg::FRAME_LEN,
   parameter int DW        = fft_pkg::DW
) (
   input  logic                         i_clk,
   input  logic                         i_reset,
   input  logic                         i_valid_in,
   input  logic [DW-1:0]                i_data_a_real,
   input  logic [DW-1:0]                i_data_a_imag,
   input  logic [DW-1:0]                i_data_b_real,
   input  logic [DW-1:0]                i_data_b_imag,
   output logic                         o_valid,
   input  logic                         i_ready,
   output logic [DW-1:0]                o_data_real,
   output logic [DW-1:0]                o_data_imag,
   output logic [$clog2(FRAME_LEN)-1:0] o_index,
   output logic                         o_last,
   output logic                         o_overflow,
   output logic [$clog2(DEPTH):0]      o_level
);

   import fft_pkg::*;

   localparam int IW = $clog2(FRAME_LEN);

   typedef enum logic {PH_A, PH_B} phase_e;

   phase_e        phase_q, phase_d;
   cplx_t         slot_q, slot_d, nxt;
   cplx_pair_t    wpair, head;
   logic          vld_q, vld_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          ovf_q, ovf_d;
   logic          head_vld, full;
   logic          hs, load, sel_b;
   logic          push, pop, adv;

   assign wpair = {i_data_a_real, i_data_a_imag,
                   i_data_b_real, i_data_b_imag};

   pair_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(cplx_pair_t))
   ) u_fifo (
      .clk_i      (i_clk),
      .rst_ni     (i_reset),
      .push_i     (push),
      .adv_i      (adv),
      .pop_i      (pop),
      .wdata_i    (wpair),
      .rdata_o    (head),
      .head_vld_o (head_vld),
      .full_o     (full),
      .level_o    (o_level)
   );

   // The read pointer advances when B is copied into the slot, so the
   // next pair's A is already prefetched when B is handshaken.
   always_comb begin
      hs      = vld_q && i_ready;
      pop     = hs && (phase_q == PH_B);
      push    = i_valid_in && (!full || pop);
      load    = (!vld_q || i_ready) && head_vld;
      sel_b   = (phase_q == PH_B) ^ hs;
      adv     = load && sel_b;
      nxt     = sel_b ? head.b : head.a;
      phase_d = phase_q;
      if (hs) phase_d = (phase_q == PH_A) ? PH_B : PH_A;
      vld_d   = load ? 1'b1 : (hs ? 1'b0 : vld_q);
      slot_d  = slot_q;
      if (load) begin
`ifdef FFT_OUT_SCALE_EN
         slot_d.re = $signed(nxt.re) >>> 1;
         slot_d.im = $signed(nxt.im) >>> 1;
`else
         slot_d = nxt;
`endif
      end
      idx_d   = idx_q + IW'(hs);
      ovf_d   = ovf_q | (i_valid_in & ~push);
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         phase_q <= PH_A;
         slot_q  <= '0;
         vld_q   <= 1'b0;
         idx_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         phase_q <= phase_d;
         slot_q  <= slot_d;
         vld_q   <= vld_d;
         idx_q   <= idx_d;
         ovf_q   <= ovf_d;
      end
   end

   assign o_valid     = vld_q;
   assign o_data_real = slot_q.re;
   assign o_data_imag = slot_q.im;
   assign o_index     = idx_q;
   assign o_last      = (idx_q == IW'(FRAME_LEN - 1));
   assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_fft_pair_serializer.sv
// tb_fft_pair_serializer: random and directed stimulus against a
// sample-queue model of the pair serializer.
module tb_fft_pair_serializer;

   localparam int DEPTH     = 512;
   localparam int FRAME_LEN = 1024;
   localparam int DW        = 32;

   typedef struct {
      logic [DW-1:0] re;
      logic [DW-1:0] im;
   } samp_t;

   logic          clk;
   logic          i_reset;
   logic          i_valid_in;
   logic [DW-1:0] a_re, a_im, b_re, b_im;
   logic          o_valid;
   logic          i_ready;
   logic [DW-1:0] o_data_real, o_data_imag;
   logic [9:0]    o_index;
   logic          o_last, o_overflow;
   logic [9:0]    o_level;

   fft_pair_serializer #(
      .DEPTH     (DEPTH),
      .FRAME_LEN (FRAME_LEN),
      .DW        (DW)
   ) dut (
      .i_clk         (clk),
      .i_reset       (i_reset),
      .i_valid_in    (i_valid_in),
      .i_data_a_real (a_re),
      .i_data_a_imag (a_im),
      .i_data_b_real (b_re),
      .i_data_b_imag (b_im),
      .o_valid       (o_valid),
      .i_ready       (i_ready),
      .o_data_real   (o_data_real),
      .o_data_imag   (o_data_imag),
      .o_index       (o_index),
      .o_last        (o_last),
      .o_overflow    (o_overflow),
      .o_level       (o_level)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int    n_cmp = 0;
   int    n_bad = 0;
   samp_t exp_q[$];
   int    m_cnt, m_idx;
   bit    m_ph, m_ovf;
   bit    held;
   logic [DW-1:0] h_re, h_im;
   logic [9:0]    h_idx;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] sc(input logic [DW-1:0] x);
`ifdef FFT_OUT_SCALE_EN
      return $signed(x) >>> 1;
`else
      return x;
`endif
   endfunction

   task automatic do_reset();
      i_reset    = 1'b0;
      i_valid_in = 1'b0;
      i_ready    = 1'b0;
      #1;
      chk("rst_valid", o_valid, 0);
      chk("rst_re", o_data_real, 0);
      chk("rst_im", o_data_imag, 0);
      chk("rst_idx", o_index, 0);
      chk("rst_last", o_last, 0);
      chk("rst_ovf", o_overflow, 0);
      chk("rst_level", o_level, 0);
      @(negedge clk);
      @(negedge clk);
      i_reset = 1'b1;
      exp_q.delete();
      m_cnt = 0;
      m_idx = 0;
      m_ph  = 0;
      m_ovf = 0;
      held  = 0;
   endtask

   // Called at a negedge: check state left by the last edge, drive the
   // next edge and update the model with what that edge will do.
   task automatic step(input bit v, input logic [DW-1:0] ar,
                       input logic [DW-1:0] ai, input logic [DW-1:0] br,
                       input logic [DW-1:0] bi, input bit rdy);
      bit    hs, popn, acc;
      samp_t e;
      chk("level", o_level, m_cnt);
      chk("ovf", o_overflow, m_ovf);
      if (held) begin
         chk("hold_valid", o_valid, 1);
         chk("hold_re", o_data_real, h_re);
         chk("hold_im", o_data_imag, h_im);
         chk("hold_idx", o_index, h_idx);
      end
      i_valid_in = v;
      a_re = ar; a_im = ai; b_re = br; b_im = bi;
      i_ready = rdy;
      hs   = o_valid && rdy;
      popn = 0;
      if (hs) begin
         if (exp_q.size() == 0) begin
            chk("extra_sample", o_valid, 0);
         end else begin
            e = exp_q.pop_front();
            chk("out_re", o_data_real, e.re);
            chk("out_im", o_data_imag, e.im);
            chk("out_idx", o_index, m_idx);
            chk("out_last", o_last, m_idx == FRAME_LEN - 1);
         end
         m_idx = (m_idx + 1) % FRAME_LEN;
         popn  = m_ph;
         m_ph  = !m_ph;
      end
      held  = o_valid && !rdy;
      h_re  = o_data_real;
      h_im  = o_data_imag;
      h_idx = o_index;
      acc = v && (m_cnt < DEPTH || popn);
      if (acc) begin
         exp_q.push_back('{sc(ar), sc(ai)});
         exp_q.push_back('{sc(br), sc(bi)});
      end else if (v) begin
         m_ovf = 1;
      end
      m_cnt = m_cnt + int'(acc) - int'(popn);
      @(negedge clk);
   endtask

   task automatic idle(input bit rdy);
      step(0, 0, 0, 0, 0, rdy);
   endtask

   task automatic push_rand(input bit rdy);
      step(1, $urandom, $urandom, $urandom, $urandom, rdy);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 4000) begin
         idle(1);
         n++;
      end
      idle(1);
      chk("drain_left", exp_q.size(), 0);
   endtask

   initial begin
      i_reset = 1'b1; i_valid_in = 1'b0; i_ready = 1'b0;
      a_re = '0; a_im = '0; b_re = '0; b_im = '0;
      @(negedge clk);
      do_reset();

      // single pair latency
      step(1, 32'h10, 32'h20, 32'h30, 32'h40, 1);
      chk("lat_t0", o_valid, 0);
      idle(1);
      chk("lat_t1", o_valid, 0);
      idle(1);
      chk("lat_t2", o_valid, 1);
      chk("lat_a_re", o_data_real, sc(32'h10));
      chk("lat_a_idx", o_index, 0);
      idle(1);
      chk("lat_t3", o_valid, 1);
      chk("lat_b_re", o_data_real, sc(32'h30));
      chk("lat_b_idx", o_index, 1);
      drain();

      // scaling corner values
      step(1, 32'hFFFF_FFF3, 32'h0000_0007, 32'h8000_0000, 32'h7FFF_FFFF, 1);
      drain();

      // full frame plus one pair, back to back
      do_reset();
      for (int i = 0; i < 513; i++) push_rand(1);
      drain();
      chk("frame_ovf", o_overflow, 0);

      // backpressure hold
      do_reset();
      for (int i = 0; i < 4; i++) push_rand(1);
      for (int i = 0; i < 5; i++) idle(0);
      idle(1); idle(0); idle(0); idle(1);
      drain();

      // overflow: 513 pairs into 512 slots, sink stalled
      do_reset();
      for (int i = 0; i < 513; i++) push_rand(0);
      idle(0);
      chk("ovf_level", o_level, DEPTH);
      chk("ovf_flag", o_overflow, 1);
      drain();
      chk("ovf_sticky", o_overflow, 1);

      // push on full only in B-handshake cycles
      do_reset();
      for (int i = 0; i < DEPTH; i++) push_rand(0);
      idle(0);
      for (int i = 0; i < 40; i++)
         step(o_valid && m_ph, $urandom, $urandom, $urandom,
              $urandom, 1);
      chk("fullpop_ovf", o_overflow, 0);
      chk("fullpop_level", o_level, DEPTH);
      drain();

      // random traffic with a reset in the middle of a frame
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         if (c == 2500) do_reset();
         step($urandom_range(0, 99) < 60, $urandom, $urandom,
              $urandom, $urandom, $urandom_range(0, 99) < 70);
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
